// File: rtl/sobel_pkg.sv
// Shared constants and width helpers for the Sobel edge detector.
// Mode encodings, fixed pipeline latency, datapath width functions.
package sobel_pkg;

  localparam logic [1:0] MODE_BIN = 2'd0;
  localparam logic [1:0] MODE_MAG = 2'd1;
  localparam logic [1:0] MODE_GX  = 2'd2;
  localparam logic [1:0] MODE_GY  = 2'd3;

  localparam int SOBEL_LAT = 5;

  function automatic int sum_w(input int dw);
    return dw + 2;
  endfunction

  function automatic int mag_w(input int dw);
    return dw + 3;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Two-line buffer plus column shift registers forming the 3x3 window.
// o_win index = 3*row + col, row 0 = oldest line, col 0 = leftmost.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MAX_W  = 1920,
  parameter int ADDR_W = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_de,
  input  logic                   i_we,
  input  logic [ADDR_W-1:0]      i_col,
  input  logic [DATA_W-1:0]      i_y,
  output logic [8:0][DATA_W-1:0] o_win
);

  logic [DATA_W-1:0] r_lb0 [MAX_W];
  logic [DATA_W-1:0] r_lb1 [MAX_W];
  logic [DATA_W-1:0] w_top;
  logic [DATA_W-1:0] w_mid;
  logic [8:0][DATA_W-1:0] r_win;

  assign w_top = r_lb0[i_col];
  assign w_mid = r_lb1[i_col];
  assign o_win = r_win;

  // Read-before-write: the older line moves down as the new pixel lands.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_lb0[i_col] <= r_lb1[i_col];
      r_lb1[i_col] <= i_y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win <= '0;
    end else if (i_de) begin
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= w_top;
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= w_mid;
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= i_y;
    end
  end

endmodule

// File: rtl/sobel_edge_param.sv
// Parametrised Sobel edge detector on the luma path, fixed 5-clock latency.
// Counters, frame-synchronous config, arithmetic pipe and sync delays.
module sobel_edge_param
  import sobel_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MAX_W      = 1920,
  parameter int ADDR_W     = 11,
  parameter int THRESH_RST = 96,
  parameter int EDGE_POL   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W+2:0] threshold,
  input  logic [1:0]        mode,
  input  logic              in_vs,
  input  logic              in_hs,
  input  logic              in_de,
  input  logic [DATA_W-1:0] in_y,
  output logic              out_vs,
  output logic              out_hs,
  output logic              out_de,
  output logic [DATA_W-1:0] out_data
);

  localparam int SW = sum_w(DATA_W);
  localparam int GW = mag_w(DATA_W);
  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(MAX_W - 1);
  localparam logic [GW-1:0] PIX_MAX = GW'((1 << DATA_W) - 1);
  localparam logic POL = (EDGE_POL != 0);

  function automatic logic [SW-1:0] tri_sum(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] c
  );
    return SW'(a) + (SW'(b) << 1) + SW'(c);
  endfunction

  function automatic logic [SW-1:0] abs_d(
    input logic [SW-1:0] a,
    input logic [SW-1:0] b
  );
    return (a >= b) ? a - b : b - a;
  endfunction

  function automatic logic [DATA_W-1:0] sat(
    input logic [GW-1:0] x
  );
    return (x > PIX_MAX) ? '1 : x[DATA_W-1:0];
  endfunction

  logic              r_vs_prev, r_de_prev, r_ovf;
  logic [ADDR_W-1:0] r_col, r_row, w_row;
  logic              w_vs_rise, w_de_fall, w_bord;
  logic [4:0]        r_vs_p, r_hs_p, r_de_p;
  logic [3:0]        r_bd_p;
  logic [8:0][DATA_W-1:0] w_win;
  logic [SW-1:0]     r_gxp, r_gxn, r_gyp, r_gyn;
  logic [SW-1:0]     r_ax, r_ay, r_ax4, r_ay4;
  logic [GW-1:0]     r_g;
  logic [GW-1:0]     r_thr_pend, r_thr, w_thr;
  logic [1:0]        r_mode_pend, r_mode, w_mode;
  logic              w_cfg_go;
  logic [DATA_W-1:0] w_res, r_out;

  assign w_vs_rise = in_vs & ~r_vs_prev;
  assign w_de_fall = ~in_de & r_de_prev;
  assign w_row     = w_vs_rise ? '0 : r_row;
  assign w_bord    = (w_row < ADDR_W'(2)) | (r_col < ADDR_W'(2)) | r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_prev <= 1'b0;
      r_de_prev <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_vs_prev <= in_vs;
      r_de_prev <= in_de;
      if (in_de) begin
        if (r_col != COL_MAX) r_col <= r_col + 1'b1;
        else                  r_ovf <= 1'b1;
      end else if (w_de_fall) begin
        r_col <= '0;
        r_ovf <= 1'b0;
      end
      if (w_vs_rise)                   r_row <= '0;
      else if (w_de_fall && r_row != '1) r_row <= r_row + 1'b1;
    end
  end

  sobel_line_buf #(
    .DATA_W (DATA_W),
    .MAX_W  (MAX_W),
    .ADDR_W (ADDR_W)
  ) u_lb (
    .clk   (clk),
    .rst   (rst),
    .i_de  (in_de),
    .i_we  (in_de & ~r_ovf),
    .i_col (r_col),
    .i_y   (in_y),
    .o_win (w_win)
  );

  // Config swaps in exactly when the new frame's first cycle reaches the output stage.
  assign w_cfg_go = r_vs_p[3] & ~r_vs_p[4];
  assign w_thr    = w_cfg_go ? r_thr_pend : r_thr;
  assign w_mode   = w_cfg_go ? r_mode_pend : r_mode;

  always_comb begin
    w_res = '0;
    unique case (w_mode)
      MODE_BIN: w_res = ((r_g >= w_thr) ^ POL) ? '0 : '1;
      MODE_MAG: w_res = sat(r_g);
      MODE_GX:  w_res = sat(GW'(r_ax4));
      MODE_GY:  w_res = sat(GW'(r_ay4));
      default:  w_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_p      <= '0;
      r_hs_p      <= '0;
      r_de_p      <= '0;
      r_bd_p      <= '0;
      r_gxp       <= '0;
      r_gxn       <= '0;
      r_gyp       <= '0;
      r_gyn       <= '0;
      r_ax        <= '0;
      r_ay        <= '0;
      r_ax4       <= '0;
      r_ay4       <= '0;
      r_g         <= '0;
      r_thr_pend  <= GW'(THRESH_RST);
      r_thr       <= GW'(THRESH_RST);
      r_mode_pend <= MODE_BIN;
      r_mode      <= MODE_BIN;
      r_out       <= '0;
    end else begin
      r_vs_p <= {r_vs_p[3:0], in_vs};
      r_hs_p <= {r_hs_p[3:0], in_hs};
      r_de_p <= {r_de_p[3:0], in_de};
      r_bd_p <= {r_bd_p[2:0], w_bord};
      if (w_vs_rise) begin
        r_thr_pend  <= threshold;
        r_mode_pend <= mode;
      end
      r_thr  <= w_thr;
      r_mode <= w_mode;
      r_gxp  <= tri_sum(w_win[2], w_win[5], w_win[8]);
      r_gxn  <= tri_sum(w_win[0], w_win[3], w_win[6]);
      r_gyp  <= tri_sum(w_win[0], w_win[1], w_win[2]);
      r_gyn  <= tri_sum(w_win[6], w_win[7], w_win[8]);
      r_ax   <= abs_d(r_gxp, r_gxn);
      r_ay   <= abs_d(r_gyp, r_gyn);
      r_ax4  <= r_ax;
      r_ay4  <= r_ay;
      r_g    <= GW'(r_ax) + GW'(r_ay);
      r_out  <= (r_de_p[3] & ~r_bd_p[3]) ? w_res : '0;
    end
  end

  assign out_vs   = r_vs_p[4];
  assign out_hs   = r_hs_p[4];
  assign out_de   = r_de_p[4];
  assign out_data = r_out;

endmodule
